baccarat_dealer: RTL and testbench
==================================

// Module: baccarat_dealer
// PURPOSE
// - Card-issuing side of the hand-scoring path. Deals one baccarat round (player and dealer hands) into six card registers.
// - The six card registers feed two external scorehand instances. Their mod-10 totals return on pscore/dscore.
// - The FSM sequences the deals, applies the third-card rules and registers the round outcome.
// PARAMETERS
// - CARD_W   4   card code width; 1=A, 2..10, 11=J, 12=Q, 13=K, 0=no card
// - SCORE_W  4   width of returned hand totals (legal range 0..9)
// PORTS
// - slow_clock   in   1        system clock, rising edge
// - reset        in   1        asynchronous, active-high reset
// - start        in   1        request a new round; sampled in IDLE and DONE only
// - new_card     in   CARD_W   card from the deck source; legal values 1..13
// - pscore       in   SCORE_W  player total from scorehand(pcard1..3), combinational
// - dscore       in   SCORE_W  dealer total from scorehand(dcard1..3), combinational
// - pcard1..3    out  CARD_W   player card registers
// - dcard1..3    out  CARD_W   dealer card registers
// - busy         out  1        high in every state except IDLE and DONE
// - done         out  1        high in DONE
// - player_win   out  1        outcome flag, valid while done=1
// - dealer_win   out  1        outcome flag, valid while done=1
// - tie          out  1        outcome flag, valid while done=1
// BEHAVIOUR
// - Reset state: FSM=IDLE; all card registers=0; busy, done, player_win, dealer_win, tie=0.
// - Reset takes effect immediately (asynchronous), including mid-round.
// - States: IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL, DEAL_P3, EVAL_D, DEAL_D3, FINAL, DONE.
// - Round start: start=1 in IDLE or DONE -> next edge: all cards and outcome flags clear to 0; state=DEAL_P1.
// - start while busy is ignored.
// - Each DEAL_x state: if new_card is in 1..13, load it into its register at the edge and advance.
//   - Otherwise (0, 14, 15): hold the state; the register stays 0.
// - Deal order: DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2 -> EVAL.
// - EVAL: pscore/dscore reflect the 2-card hands (scorehand is combinational off the registers).
//   - pscore>=8 or dscore>=8 (natural): go to FINAL.
//   - else pscore<=5: go to DEAL_P3.
//   - else (player stands on 6/7): dscore<=5 -> DEAL_D3, otherwise FINAL.
// - DEAL_P3 -> EVAL_D. EVAL_D computes v = face score of pcard3 (0 if pcard3>=10, else pcard3), then:
//   - draw (DEAL_D3) if dscore<=2;
//   - or dscore==3 and v!=8;
//   - or dscore==4 and v in 2..7;
//   - or dscore==5 and v in 4..7;
//   - or dscore==6 and v in 6..7;
//   - otherwise (including dscore==7) go to FINAL.
// - DEAL_D3 -> FINAL.
// - FINAL: one cycle; register the outcome at the edge, exactly one flag set:
//   - pscore>dscore -> player_win; dscore>pscore -> dealer_win; equal -> tie.
// - FINAL -> DONE. DONE holds until start=1.
// - Unused third-card registers remain 0.
// - Latency from the start-accept edge, no stalls:
//   - natural or both stand: done at edge 7;
//   - player draws only: edge 9;
//   - banker draws only: edge 8;
//   - both draw: edge 10.
// - Arithmetic: compares are unsigned on SCORE_W bits. pscore/dscore are never latched; they are used only in EVAL, EVAL_D and FINAL.
// TESTING
// - Natural: cards P1=4, D1=2, P2=4, D2=3 -> p=8, d=5; pcard3=dcard3=0; player_win=1; done 7 edges after start.
// - Player draws, banker on 0: P=2,3 D=13,11 P3=9 D3=7 -> banker draws; p=4, d=7; dealer_win=1.
// - Banker 6 rule: P=10,3 D=3,3 P3=7 -> D3 drawn (feed 1), d=7, dealer_win=1.
//   - Repeat with P3=5 -> dcard3=0; p=8, d=6; player_win=1.
// - Player stands, banker draws: P=3,3 D=2,3 D3=1 -> pcard3=0; p=6, d=6; tie=1.
// - Stall: new_card=0 for 3 cycles in DEAL_D1 -> dcard1 holds 0, busy=1; then new_card=5 -> dcard1=5 next edge.
//   - Also: start pulses while busy have no effect.
// - Mid-round reset after P2 is loaded -> all cards, busy, done and flags read 0 immediately.
//   - After release, start begins a fresh round at DEAL_P1.

Source files
------------

// File: rtl/baccarat_dealer_if.sv
// Deal-path bundle between the dealer FSM and its environment (deck source, scorehand pair).
// Latency: none; this is wiring only.
// Backpressure: an illegal new_card code stalls the dealer in its current deal state.
interface baccarat_dealer_if #(
    parameter int CARD_W  = 4,
    parameter int SCORE_W = 4
);
    logic               start;
    logic [CARD_W-1:0]  new_card;
    logic [SCORE_W-1:0] pscore;
    logic [SCORE_W-1:0] dscore;
    logic [CARD_W-1:0]  pcard1;
    logic [CARD_W-1:0]  pcard2;
    logic [CARD_W-1:0]  pcard3;
    logic [CARD_W-1:0]  dcard1;
    logic [CARD_W-1:0]  dcard2;
    logic [CARD_W-1:0]  dcard3;
    logic               busy;
    logic               done;
    logic               player_win;
    logic               dealer_win;
    logic               tie;

    // Environment side: deck source, start request and the scorehand totals.
    modport master (
        output start, new_card, pscore, dscore,
        input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
        input  busy, done, player_win, dealer_win, tie
    );

    // Dealer side.
    modport slave (
        input  start, new_card, pscore, dscore,
        output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
        output busy, done, player_win, dealer_win, tie
    );
endinterface

// File: rtl/baccarat_dealer.sv
// Deals one baccarat round into six card registers, applies third-card rules, registers the outcome.
// Latency: done 7..10 edges after the start-accept edge (counting that edge as 1), plus stall cycles.
// Backpressure: each deal state holds until new_card is a legal code 1..13; start ignored while busy.
module baccarat_dealer #(
    parameter int CARD_W  = 4,
    parameter int SCORE_W = 4
) (
    input  logic                 slow_clock,
    input  logic                 reset,
    baccarat_dealer_if.slave     bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEAL_P1,
        S_DEAL_D1,
        S_DEAL_P2,
        S_DEAL_D2,
        S_EVAL,
        S_DEAL_P3,
        S_EVAL_D,
        S_DEAL_D3,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [CARD_W-1:0]  CARD_MIN  = CARD_W'(1);
    localparam logic [CARD_W-1:0]  CARD_MAX  = CARD_W'(13);
    localparam logic [CARD_W-1:0]  CARD_TEN  = CARD_W'(10);
    localparam logic [SCORE_W-1:0] NATURAL   = SCORE_W'(8);
    localparam logic [SCORE_W-1:0] DRAW_MAX  = SCORE_W'(5);

    state_t             state_q, state_d;
    logic [CARD_W-1:0]  p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
    logic [CARD_W-1:0]  d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic               pwin_q, pwin_d, dwin_q, dwin_d, tie_q, tie_d;

    logic               card_ok;
    logic [CARD_W-1:0]  p3_face;
    logic               banker_draws;

    assign card_ok = (bus.new_card >= CARD_MIN) && (bus.new_card <= CARD_MAX);
    // Face cards and tens count zero toward a baccarat total.
    assign p3_face = (p3_q >= CARD_TEN) ? '0 : p3_q;

    // Banker third-card table, indexed by banker total and the player's third-card value.
    always_comb begin
        banker_draws = 1'b0;
        if (bus.dscore <= SCORE_W'(2)) begin
            banker_draws = 1'b1;
        end else if (bus.dscore == SCORE_W'(3)) begin
            banker_draws = (p3_face != CARD_W'(8));
        end else if (bus.dscore == SCORE_W'(4)) begin
            banker_draws = (p3_face >= CARD_W'(2)) && (p3_face <= CARD_W'(7));
        end else if (bus.dscore == SCORE_W'(5)) begin
            banker_draws = (p3_face >= CARD_W'(4)) && (p3_face <= CARD_W'(7));
        end else if (bus.dscore == SCORE_W'(6)) begin
            banker_draws = (p3_face >= CARD_W'(6)) && (p3_face <= CARD_W'(7));
        end
    end

    // Next-state logic: deal sequencing, stand/draw decisions and outcome capture.
    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        p3_d    = p3_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        pwin_d  = pwin_q;
        dwin_d  = dwin_q;
        tie_d   = tie_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    p1_d    = '0;
                    p2_d    = '0;
                    p3_d    = '0;
                    d1_d    = '0;
                    d2_d    = '0;
                    d3_d    = '0;
                    pwin_d  = 1'b0;
                    dwin_d  = 1'b0;
                    tie_d   = 1'b0;
                    state_d = S_DEAL_P1;
                end
            end
            S_DEAL_P1: begin
                if (card_ok) begin
                    p1_d    = bus.new_card;
                    state_d = S_DEAL_D1;
                end
            end
            S_DEAL_D1: begin
                if (card_ok) begin
                    d1_d    = bus.new_card;
                    state_d = S_DEAL_P2;
                end
            end
            S_DEAL_P2: begin
                if (card_ok) begin
                    p2_d    = bus.new_card;
                    state_d = S_DEAL_D2;
                end
            end
            S_DEAL_D2: begin
                if (card_ok) begin
                    d2_d    = bus.new_card;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if ((bus.pscore >= NATURAL) || (bus.dscore >= NATURAL)) begin
                    state_d = S_FINAL;
                end else if (bus.pscore <= DRAW_MAX) begin
                    state_d = S_DEAL_P3;
                end else if (bus.dscore <= DRAW_MAX) begin
                    state_d = S_DEAL_D3;
                end else begin
                    state_d = S_FINAL;
                end
            end
            S_DEAL_P3: begin
                if (card_ok) begin
                    p3_d    = bus.new_card;
                    state_d = S_EVAL_D;
                end
            end
            S_EVAL_D: begin
                state_d = banker_draws ? S_DEAL_D3 : S_FINAL;
            end
            S_DEAL_D3: begin
                if (card_ok) begin
                    d3_d    = bus.new_card;
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                pwin_d  = (bus.pscore > bus.dscore);
                dwin_d  = (bus.dscore > bus.pscore);
                tie_d   = (bus.pscore == bus.dscore);
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, card and outcome registers; reset clears everything at once, even mid-round.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            p1_q    <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            pwin_q  <= 1'b0;
            dwin_q  <= 1'b0;
            tie_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            pwin_q  <= pwin_d;
            dwin_q  <= dwin_d;
            tie_q   <= tie_d;
        end
    end

    assign bus.pcard1     = p1_q;
    assign bus.pcard2     = p2_q;
    assign bus.pcard3     = p3_q;
    assign bus.dcard1     = d1_q;
    assign bus.dcard2     = d2_q;
    assign bus.dcard3     = d3_q;
    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.player_win = pwin_q;
    assign bus.dealer_win = dwin_q;
    assign bus.tie        = tie_q;

endmodule

// File: tb/tb_baccarat_dealer.sv
// Directed bench for baccarat_dealer with a behavioural scorehand pair and an expected-round queue.
// Latency: each round's done edge is compared against the expected edge count.
// Backpressure: stall cycles are injected with illegal card codes in one round.
module tb_baccarat_dealer;

    logic slow_clock = 1'b0;
    logic reset      = 1'b1;
    always #5 slow_clock = ~slow_clock;

    baccarat_dealer_if #(.CARD_W(4), .SCORE_W(4)) bif ();

    baccarat_dealer #(.CARD_W(4), .SCORE_W(4)) dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .bus        (bif)
    );

    // Behavioural scorehand: tens and face cards count zero, total taken mod 10.
    function automatic int face(input logic [3:0] c);
        return (c >= 4'd10) ? 0 : int'(c);
    endfunction

    assign bif.pscore = 4'((face(bif.pcard1) + face(bif.pcard2) + face(bif.pcard3)) % 10);
    assign bif.dscore = 4'((face(bif.dcard1) + face(bif.dcard2) + face(bif.dcard3)) % 10);

    typedef struct {
        int         lat;
        logic [3:0] p1, p2, p3, d1, d2, d3;
        logic       pw, dw, ti;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   edges = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic edge1();
        @(posedge slow_clock);
        #1;
    endtask

    // Queue the expected round and issue start; accept edge counts as edge 1.
    task automatic begin_round(input int lat,
                               input logic [3:0] p1, input logic [3:0] p2, input logic [3:0] p3,
                               input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                               input logic pw, input logic dw, input logic ti);
        exp_t e;
        e.lat = lat; e.p1 = p1; e.p2 = p2; e.p3 = p3;
        e.d1 = d1; e.d2 = d2; e.d3 = d3;
        e.pw = pw; e.dw = dw; e.ti = ti;
        sb.push_back(e);
        bif.start    = 1'b1;
        bif.new_card = 4'd0;
        edge1();
        bif.start = 1'b0;
        edges     = 1;
        chk("start_busy", {7'd0, bif.busy}, 8'd1);
        chk("start_clr_flags", {5'd0, bif.player_win, bif.dealer_win, bif.tie}, 8'd0);
        chk("start_clr_pcard1", {4'd0, bif.pcard1}, 8'd0);
    endtask

    task automatic feed(input logic [3:0] v);
        bif.new_card = v;
        edge1();
        edges++;
    endtask

    // Wait (bounded) for done, then pop the expected round and compare everything.
    task automatic finish_round();
        exp_t e;
        bif.new_card = 4'd0;
        while (!bif.done && edges < 30) begin
            edge1();
            edges++;
        end
        chk("done_seen", {7'd0, bif.done}, 8'd1);
        e = sb.pop_front();
        chk("latency", 8'(edges), 8'(e.lat));
        chk("pcard1", {4'd0, bif.pcard1}, {4'd0, e.p1});
        chk("pcard2", {4'd0, bif.pcard2}, {4'd0, e.p2});
        chk("pcard3", {4'd0, bif.pcard3}, {4'd0, e.p3});
        chk("dcard1", {4'd0, bif.dcard1}, {4'd0, e.d1});
        chk("dcard2", {4'd0, bif.dcard2}, {4'd0, e.d2});
        chk("dcard3", {4'd0, bif.dcard3}, {4'd0, e.d3});
        chk("player_win", {7'd0, bif.player_win}, {7'd0, e.pw});
        chk("dealer_win", {7'd0, bif.dealer_win}, {7'd0, e.dw});
        chk("tie", {7'd0, bif.tie}, {7'd0, e.ti});
        chk("busy_at_done", {7'd0, bif.busy}, 8'd0);
    endtask

    initial begin
        bif.start    = 1'b0;
        bif.new_card = 4'd0;

        // Reset state.
        edge1();
        edge1();
        chk("rst_busy", {7'd0, bif.busy}, 8'd0);
        chk("rst_done", {7'd0, bif.done}, 8'd0);
        chk("rst_flags", {5'd0, bif.player_win, bif.dealer_win, bif.tie}, 8'd0);
        chk("rst_cards", {bif.pcard1, bif.dcard3}, 8'd0);
        reset = 1'b0;
        edge1();
        chk("idle_busy", {7'd0, bif.busy}, 8'd0);

        // Player natural: p=8, d=5.
        begin_round(7, 4'd4, 4'd4, 4'd0, 4'd2, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0);
        feed(4'd4); feed(4'd2); feed(4'd4); feed(4'd3);
        finish_round();

        // Player draws 9 (p=4); banker on 0 draws 7 (d=7).
        begin_round(10, 4'd2, 4'd3, 4'd9, 4'd13, 4'd11, 4'd7, 1'b0, 1'b1, 1'b0);
        feed(4'd2); feed(4'd13); feed(4'd3); feed(4'd11);
        feed(4'd0); feed(4'd9); feed(4'd0); feed(4'd7);
        finish_round();

        // Banker on 6 with player third card 7: banker draws 1 (d=7), p=0.
        begin_round(10, 4'd10, 4'd3, 4'd7, 4'd3, 4'd3, 4'd1, 1'b0, 1'b1, 1'b0);
        feed(4'd10); feed(4'd3); feed(4'd3); feed(4'd3);
        feed(4'd0); feed(4'd7); feed(4'd0); feed(4'd1);
        finish_round();

        // Banker on 6 with player third card 5: banker stands, p=8, d=6.
        begin_round(9, 4'd10, 4'd3, 4'd5, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0);
        feed(4'd10); feed(4'd3); feed(4'd3); feed(4'd3);
        feed(4'd0); feed(4'd5);
        finish_round();

        // Player stands on 6, banker on 5 draws 1: 6-6 tie.
        begin_round(8, 4'd3, 4'd3, 4'd0, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0, 1'b1);
        feed(4'd3); feed(4'd2); feed(4'd3); feed(4'd3);
        feed(4'd0); feed(4'd1);
        finish_round();

        // Both stand on 7: tie with no third cards.
        begin_round(7, 4'd3, 4'd4, 4'd0, 4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 1'b1);
        feed(4'd3); feed(4'd3); feed(4'd4); feed(4'd4);
        finish_round();

        // Banker natural 9 against player 3.
        begin_round(7, 4'd1, 4'd2, 4'd0, 4'd4, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0);
        feed(4'd1); feed(4'd4); feed(4'd2); feed(4'd5);
        finish_round();

        // Banker on 3 stands against a player third card of 8 (p=0, d=3).
        begin_round(9, 4'd1, 4'd1, 4'd8, 4'd1, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0);
        feed(4'd1); feed(4'd1); feed(4'd1); feed(4'd2);
        feed(4'd0); feed(4'd8);
        finish_round();

        // Banker on 4 stands against a player third card of 1 (p=3, d=4).
        begin_round(9, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0);
        feed(4'd1); feed(4'd2); feed(4'd1); feed(4'd2);
        feed(4'd0); feed(4'd1);
        finish_round();

        // Stall in DEAL_D1 with illegal codes, plus a start pulse while busy; ends 7-7 tie.
        begin_round(10, 4'd1, 4'd6, 4'd0, 4'd5, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1);
        feed(4'd1);
        feed(4'd0);
        chk("stall0_dcard1", {4'd0, bif.dcard1}, 8'd0);
        chk("stall0_busy", {7'd0, bif.busy}, 8'd1);
        bif.start = 1'b1;
        feed(4'd14);
        bif.start = 1'b0;
        chk("stall14_dcard1", {4'd0, bif.dcard1}, 8'd0);
        chk("stall14_pcard1", {4'd0, bif.pcard1}, 8'd1);
        feed(4'd15);
        chk("stall15_dcard1", {4'd0, bif.dcard1}, 8'd0);
        chk("stall15_busy", {7'd0, bif.busy}, 8'd1);
        feed(4'd5);
        chk("unstall_dcard1", {4'd0, bif.dcard1}, 8'd5);
        feed(4'd6); feed(4'd2);
        finish_round();

        // Mid-round asynchronous reset after P2 is loaded.
        bif.start = 1'b1;
        edge1();
        bif.start = 1'b0;
        feed(4'd4); feed(4'd2); feed(4'd4);
        chk("pre_rst_pcard2", {4'd0, bif.pcard2}, 8'd4);
        #1 reset = 1'b1;
        #1;
        chk("arst_pcards", {bif.pcard1, bif.pcard2}, 8'd0);
        chk("arst_dcard1", {4'd0, bif.dcard1}, 8'd0);
        chk("arst_busy_done", {6'd0, bif.busy, bif.done}, 8'd0);
        chk("arst_flags", {5'd0, bif.player_win, bif.dealer_win, bif.tie}, 8'd0);
        edge1();
        reset = 1'b0;
        edge1();
        chk("post_rst_busy", {7'd0, bif.busy}, 8'd0);

        // Fresh round after reset release: player natural 9 vs 7.
        begin_round(7, 4'd4, 4'd5, 4'd0, 4'd3, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0);
        feed(4'd4); feed(4'd3); feed(4'd5); feed(4'd4);
        finish_round();

        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
